mac_r_gmii_tte: RTL

- GMII/MII receive MAC. It is the receive-side counterpart of the GMII transmit MAC.
- Deserialises rx_d and strips the preamble/SFD, then checks the FCS and frame length.
- Writes the payload (FCS removed) into the receive data FIFO, then one 16-bit pointer word per frame.
- Classifies TTE and PTP frames and captures an SFD timestamp from counter_ns for PTP frames.

---
 rtl/mac_pkg.sv | 40 ++++
 rtl/mac_r_gmii_tte_crc32_d8.sv | 25 ++
 rtl/mac_r_gmii_tte.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants, pointer type codes and FSM state encoding for the GMII/MII receive MAC.
package mac_pkg;

    localparam logic [15:0] ETH_TYPE_TTE  = 16'h891D;
    localparam logic [15:0] ETH_TYPE_PTP  = 16'h88F7;

    localparam logic [3:0]  TYPE_NORMAL   = 4'h1;
    localparam logic [3:0]  TYPE_TTE      = 4'h2;
    localparam logic [3:0]  TYPE_SYNC     = 4'h4;
    localparam logic [3:0]  TYPE_FOLLOW   = 4'h8;
    localparam logic [3:0]  TYPE_DREQ     = 4'h0;

    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    // Residue expressed MSB-first; the register runs reflected, so it is bit-reversed before compare
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_STATUS   = 3'd3,
        ST_DROP     = 3'd4
    } rx_state_e;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac_r_gmii_tte_crc32_d8.sv
// Combinational CRC-32 (reflected 0x04C11DB7) update over one byte; shared with the transmit MAC.
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_v;

    // Eight reflected shift steps, data consumed LSB first
    always_comb begin
        crc_v = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0]) begin
                crc_v = (crc_v >> 1) ^ CRC_POLY_REFL;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/mac_r_gmii_tte.sv
// GMII/MII receive MAC with FCS/length check, TTE/PTP classification and pointer/timestamp FIFO writes.
// Optional PTP timestamping is enabled by defining MAC_R_PTP_TS_EN.
module mac_r_gmii_tte
    import mac_pkg::*;
#(
    parameter int DATA_FIFO_THRESH = 2578,
    parameter int MIN_LEN          = 60,
    parameter int MAX_LEN          = 1514
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [1:0]  speed,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_d,
    input  logic [31:0] counter_ns,
    output logic        data_fifo_wr,
    output logic [7:0]  data_fifo_dout,
    input  logic [11:0] data_fifo_depth,
    output logic        ptr_fifo_wr,
    output logic [15:0] ptr_fifo_dout,
    input  logic        ptr_fifo_full,
    output logic        ts_fifo_wr,
    output logic [31:0] ts_fifo_dout,
    input  logic        ts_fifo_full,
    output logic [15:0] drop_cnt
);

    localparam logic [11:0] THRESH_W  = 12'(DATA_FIFO_THRESH);
    localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);

    rx_state_e   state_r;
    logic        nib_phase_r;
    logic [3:0]  nib_lo_r;
    logic [3:0]  pre_cnt_r;
    logic [11:0] byte_cnt_r;
    logic [31:0] crc_r;
    logic [31:0] dly_r;
    logic [15:0] etype_r;
    logic        rx_er_seen_r;
    logic        data_fifo_wr_r;
    logic [7:0]  data_fifo_dout_r;
    logic        ptr_fifo_wr_r;
    logic [15:0] ptr_fifo_dout_r;
    logic [15:0] drop_cnt_r;

    logic        gig_s;
    logic        byte_vld_s;
    logic [7:0]  byte_s;
    logic [31:0] crc_next_s;
    logic        short_s;
    logic [11:0] pay_s;
    logic        over_s;
    logic [10:0] len_s;
    logic        err_s;
    logic [3:0]  type_s;

`ifdef MAC_R_PTP_TS_EN
    logic [3:0]  msg_type_r;
    logic [31:0] ts_reg_r;
    logic        ts_fifo_wr_r;
    logic [31:0] ts_fifo_dout_r;
    logic        ptp_s;
`else
    logic        unused_s;
    assign unused_s = ^{ts_fifo_full, counter_ns};
`endif

    assign gig_s = (speed == 2'b10);

    // Nibble phase: low nibble arrives first, phase clears whenever rx_dv drops
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            nib_phase_r <= 1'b0;
            nib_lo_r    <= 4'h0;
        end else if (!rx_dv || gig_s) begin
            nib_phase_r <= 1'b0;
        end else begin
            nib_phase_r <= ~nib_phase_r;
            if (!nib_phase_r) begin
                nib_lo_r <= rx_d[3:0];
            end
        end
    end

    // Byte presentation for both interface widths
    always_comb begin
        if (gig_s) begin
            byte_vld_s = rx_dv;
            byte_s     = rx_d;
        end else begin
            byte_vld_s = rx_dv & nib_phase_r;
            byte_s     = {rx_d[3:0], nib_lo_r};
        end
    end

    crc32_d8 u_crc (
        .crc_in  (crc_r),
        .data    (byte_s),
        .crc_out (crc_next_s)
    );

    // Frame status: length clamp and error sources, evaluated as rx_dv falls in DATA
    always_comb begin
        short_s = (byte_cnt_r < 12'd4);
        pay_s   = byte_cnt_r - 12'd4;
        over_s  = !short_s && (pay_s > MAX_LEN_W);
        if (short_s) begin
            len_s = 11'd0;
        end else if (over_s) begin
            len_s = MAX_LEN_L;
        end else begin
            len_s = pay_s[10:0];
        end
        err_s = short_s | over_s | rx_er_seen_r | (len_s < MIN_LEN_L)
              | (bit_rev32(crc_r) != CRC_RESIDUE)
              | (!gig_s & nib_phase_r);
    end

    // EtherType / PTP messageType classification
    always_comb begin
        type_s = TYPE_NORMAL;
        if (etype_r == ETH_TYPE_TTE) begin
            type_s = TYPE_TTE;
        end
`ifdef MAC_R_PTP_TS_EN
        else if (etype_r == ETH_TYPE_PTP) begin
            case (msg_type_r)
                4'h0:    type_s = TYPE_SYNC;
                4'h8:    type_s = TYPE_FOLLOW;
                4'h1:    type_s = TYPE_DREQ;
                default: type_s = TYPE_NORMAL;
            endcase
        end
`endif
        else begin
            type_s = TYPE_NORMAL;
        end
    end

`ifdef MAC_R_PTP_TS_EN
    assign ptp_s = (type_s == TYPE_SYNC) || (type_s == TYPE_FOLLOW) || (type_s == TYPE_DREQ);
`endif

    // Receive FSM with registered FIFO write outputs
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            pre_cnt_r        <= 4'd0;
            byte_cnt_r       <= 12'd0;
            crc_r            <= CRC_INIT;
            dly_r            <= 32'h0;
            etype_r          <= 16'h0;
            rx_er_seen_r     <= 1'b0;
            data_fifo_wr_r   <= 1'b0;
            data_fifo_dout_r <= 8'h0;
            ptr_fifo_wr_r    <= 1'b0;
            ptr_fifo_dout_r  <= 16'h0;
            drop_cnt_r       <= 16'h0;
`ifdef MAC_R_PTP_TS_EN
            msg_type_r       <= 4'h0;
            ts_reg_r         <= 32'h0;
            ts_fifo_wr_r     <= 1'b0;
            ts_fifo_dout_r   <= 32'h0;
`endif
        end else begin
            data_fifo_wr_r <= 1'b0;
            ptr_fifo_wr_r  <= 1'b0;
`ifdef MAC_R_PTP_TS_EN
            ts_fifo_wr_r   <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (rx_dv) begin
                        state_r   <= ST_PREAMBLE;
                        pre_cnt_r <= byte_vld_s ? 4'd1 : 4'd0;
                    end
                end
                ST_PREAMBLE: begin
                    if (!rx_dv) begin
                        state_r <= ST_IDLE;
                    end else if (byte_vld_s) begin
                        if (byte_s == SFD_BYTE) begin
`ifdef MAC_R_PTP_TS_EN
                            ts_reg_r   <= counter_ns;
                            msg_type_r <= 4'h0;
`endif
                            if ((data_fifo_depth > THRESH_W) || ptr_fifo_full) begin
                                state_r    <= ST_DROP;
                                drop_cnt_r <= sat_inc16(drop_cnt_r);
                            end else begin
                                state_r      <= ST_DATA;
                                byte_cnt_r   <= 12'd0;
                                crc_r        <= CRC_INIT;
                                etype_r      <= 16'h0;
                                rx_er_seen_r <= 1'b0;
                            end
                        end else if (pre_cnt_r == 4'd15) begin
                            state_r    <= ST_DROP;
                            drop_cnt_r <= sat_inc16(drop_cnt_r);
                        end else begin
                            pre_cnt_r <= pre_cnt_r + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!rx_dv) begin
                        state_r         <= ST_STATUS;
                        ptr_fifo_wr_r   <= 1'b1;
                        ptr_fifo_dout_r <= {type_s, err_s, len_s};
`ifdef MAC_R_PTP_TS_EN
                        if (ptp_s && !err_s && !ts_fifo_full) begin
                            ts_fifo_wr_r   <= 1'b1;
                            ts_fifo_dout_r <= ts_reg_r;
                        end
`endif
                    end else begin
                        if (rx_er) begin
                            rx_er_seen_r <= 1'b1;
                        end
                        if (byte_vld_s) begin
                            crc_r <= crc_next_s;
                            dly_r <= {dly_r[23:0], byte_s};
                            if (byte_cnt_r != 12'hFFF) begin
                                byte_cnt_r <= byte_cnt_r + 12'd1;
                            end
                            if (byte_cnt_r == 12'd12) etype_r[15:8] <= byte_s;
                            if (byte_cnt_r == 12'd13) etype_r[7:0]  <= byte_s;
`ifdef MAC_R_PTP_TS_EN
                            if (byte_cnt_r == 12'd14) msg_type_r    <= byte_s[3:0];
`endif
                            // Four-byte lag keeps the FCS out of the data FIFO
                            if ((byte_cnt_r >= 12'd4) && (pay_s < MAX_LEN_W)) begin
                                data_fifo_wr_r   <= 1'b1;
                                data_fifo_dout_r <= dly_r[31:24];
                            end
                        end
                    end
                end
                ST_STATUS: begin
                    if (rx_dv) begin
                        state_r   <= ST_PREAMBLE;
                        pre_cnt_r <= byte_vld_s ? 4'd1 : 4'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!rx_dv) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_fifo_wr   = data_fifo_wr_r;
    assign data_fifo_dout = data_fifo_dout_r;
    assign ptr_fifo_wr    = ptr_fifo_wr_r;
    assign ptr_fifo_dout  = ptr_fifo_dout_r;
    assign drop_cnt       = drop_cnt_r;
`ifdef MAC_R_PTP_TS_EN
    assign ts_fifo_wr     = ts_fifo_wr_r;
    assign ts_fifo_dout   = ts_fifo_dout_r;
`else
    assign ts_fifo_wr     = 1'b0;
    assign ts_fifo_dout   = 32'h0;
`endif

endmodule
